fetch_queue: RTL and testbench

Instruction prefetch queue between a variable-latency instruction memory and the pipelined core's IF/ID register. It walks sequential fetch addresses, keeps one memory request in flight, and buffers up to DEPTH returned instructions with their PC+4. Decode consumes entries through a valid/ready handshake. A branch redirect flushes the queue and drops any stale in-flight response.

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: walks sequential fetch addresses with one memory
// request in flight and buffers returned words with their PC+4 for decode.
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] TEXT_START = 32'h00400000
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc_4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 dbg_state
);

  // Handshakes: mem side holds mem_req/mem_addr until the cycle mem_ack is
  // sampled high; decode side transfers the head when out_valid && out_ready
  // are both high on a posedge (a redirect in that cycle cancels the transfer).

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic [31:0]   req_addr, req_addr_nx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic          push, pop, room;
  logic [CW-1:0] count_nx;

  assign mem_req   = (state == WAIT) || (state == DISCARD);
  assign mem_addr  = req_addr;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc_4  = pc4_mem[rd_ptr];
  assign dbg_state = state;

  assign push     = (state == WAIT) && mem_ack && !redirect;
  assign pop      = out_valid && out_ready && !redirect;
  assign count_nx = count - CW'(pop) + CW'(push);
  // Issue only when the response is guaranteed a slot, so no overflow check is needed.
  assign room     = (count_nx < DEPTH_C);

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    if (redirect) begin
      fetch_pc_nx = redirect_pc;
      case (state)
        IDLE: begin
          state_nx    = WAIT;
          req_addr_nx = redirect_pc;
        end
        WAIT: begin
          if (mem_ack) req_addr_nx = redirect_pc;
          else         state_nx    = DISCARD;
        end
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (room) begin
            state_nx    = WAIT;
            req_addr_nx = fetch_pc;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            fetch_pc_nx = req_addr + 32'd4;
            req_addr_nx = req_addr + 32'd4;
            if (!room) state_nx = IDLE;
          end
        end
        DISCARD: begin
          // Stale response for a pre-redirect address: drop it and refetch.
          if (mem_ack) begin
            state_nx    = WAIT;
            req_addr_nx = fetch_pc;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      fetch_pc <= TEXT_START;
      req_addr <= TEXT_START;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc4_mem[i]   <= '0;
      end
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nx;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        instr_mem[wr_ptr] <= mem_rdata;
        pc4_mem[wr_ptr]   <= req_addr + 32'd4;
        wr_ptr            <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency-programmable memory responder,
// scoreboard monitor on the decode handshake, and per-cycle spot checks.
module tb_fetch_queue;

  logic        clk;
  logic        rstn;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_4;
  logic        out_ready;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  int lat   = 0;
  logic [63:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .TEXT_START(32'h00400000)) dut (
    .clk(clk), .rstn(rstn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_4(out_pc_4),
    .out_ready(out_ready), .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory responder: ack after lat wait cycles, data word = its address
  initial begin
    int  wcnt;
    logic prev_req;
    wcnt = 0; prev_req = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn || mem_ack || !prev_req) wcnt = 0;
      else wcnt++;
      if (rstn && mem_req && wcnt >= lat) begin
        mem_ack = 1'b1; mem_rdata = mem_addr;
      end else begin
        mem_ack = 1'b0; mem_rdata = '0;
      end
      prev_req = mem_req;
    end
  end

  // scoreboard monitor on the decode handshake
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready && !redirect) begin
      total++;
      n_pop++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL head_unexpected: got instr=%h pc4=%h, required none", out_instr, out_pc_4);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_instr, out_pc_4} !== e) begin
          bad++;
          $display("FAIL head_order: got instr=%h pc4=%h, required instr=%h pc4=%h",
                   out_instr, out_pc_4, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({base + 32'(4 * i), base + 32'(4 * i) + 32'd4});
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_q.delete(); n_pop = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h00400000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr,      32'd0);
    chk("rst_out_pc_4",  out_pc_4,       32'd0);
    chk("rst_count",     32'(count),     32'd0);

    // zero-wait stream
    tick(); rstn = 1'b1;
    lat = 0; out_ready = 1'b1; push_seq(32'h00400000, 32);
    @(negedge clk);
    chk("first_req_k0", 32'(mem_req), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick(); @(negedge clk);
      if (k == 1) begin
        chk("first_req_k1", 32'(mem_req),   32'd1);
        chk("first_addr",   mem_addr,       32'h00400000);
        chk("first_valid",  32'(out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_pc4",   out_pc_4,       32'h00400000 + 32'(4 * (k - 1)));
        chk("stream_addr",  mem_addr,       32'h00400000 + 32'(4 * (k - 1)));
        chk("stream_count", 32'(count),     32'd1);
      end
    end

    // backpressure
    do_reset();
    lat = 0; push_seq(32'h00400000, 16);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 9) out_ready = 1'b1;
      @(negedge clk);
      if (k == 5 || k == 8) begin
        chk("bp_count", 32'(count),   32'd4);
        chk("bp_req",   32'(mem_req), 32'd0);
        chk("bp_addr",  mem_addr,     32'h00400010);
      end
      if (k == 8) chk("bp_head", out_pc_4, 32'h00400004);
      if (k == 10) begin
        chk("bp_resume_req",   32'(mem_req), 32'd1);
        chk("bp_resume_addr",  mem_addr,     32'h00400010);
        chk("bp_resume_count", 32'(count),   32'd3);
      end
    end

    // pointer wrap with 3-cycle latency and alternating ready
    do_reset();
    lat = 3; push_seq(32'h00400000, 40);
    for (int c = 0; c < 400; c++) begin
      tick();
      out_ready = ~out_ready;
      if (n_pop >= 20) break;
    end
    chk("wrap_pops_20", 32'(n_pop >= 20), 32'd1);

    // redirect during pending request
    do_reset();
    lat = 4; out_ready = 1'b1; push_seq(32'h00400100, 8);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) begin redirect = 1'b1; redirect_pc = 32'h00400100; end
      if (k == 3) redirect = 1'b0;
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        chk("rdp_hold_addr", mem_addr,     32'h00400000);
        chk("rdp_hold_req",  32'(mem_req), 32'd1);
      end
      if (k == 3) chk("rdp_valid0", 32'(out_valid), 32'd0);
      if (k == 6) begin
        chk("rdp_new_addr", mem_addr,   32'h00400100);
        chk("rdp_dropped",  32'(count), 32'd0);
      end
      if (k == 11) begin
        chk("rdp_head_valid", 32'(out_valid), 32'd1);
        chk("rdp_head_pc4",   out_pc_4,       32'h00400104);
        chk("rdp_head_instr", out_instr,      32'h00400100);
      end
    end

    // redirect coincident with ack and pop
    do_reset();
    lat = 0; push_seq(32'h00400000, 4);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h00400200;
        exp_q.delete(); push_seq(32'h00400200, 8);
      end
      if (k == 4) redirect = 1'b0;
      @(negedge clk);
      if (k == 3) chk("rda_setup_count", 32'(count), 32'd2);
      if (k == 4) begin
        chk("rda_count", 32'(count),     32'd0);
        chk("rda_valid", 32'(out_valid), 32'd0);
        chk("rda_addr",  mem_addr,       32'h00400200);
        chk("rda_req",   32'(mem_req),   32'd1);
      end
      if (k == 5) begin
        chk("rda_head_pc4", out_pc_4,   32'h00400204);
        chk("rda_count1",   32'(count), 32'd1);
      end
    end

    // mid-operation reset
    do_reset();
    lat = 2;
    for (int k = 1; k <= 10; k++) begin
      tick(); @(negedge clk);
    end
    chk("mrst_setup_count", 32'(count),   32'd3);
    chk("mrst_setup_req",   32'(mem_req), 32'd1);
    #1 rstn = 1'b0; exp_q.delete();
    #1;
    chk("mrst_count", 32'(count),     32'd0);
    chk("mrst_req",   32'(mem_req),   32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_addr",  mem_addr,       32'h00400000);
    tick(); tick(); rstn = 1'b1;
    push_seq(32'h00400000, 16); out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(); @(negedge clk);
      if (k == 1) begin
        chk("mrst_restart_req",  32'(mem_req), 32'd1);
        chk("mrst_restart_addr", mem_addr,     32'h00400000);
      end
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
